// File: rtl/id_ex_stage.sv
// ID->EX pipeline register for the 64-bit LEGv8 core: load-use stall detection,
// branch-flush bubble insertion and EX/MEM, MEM/WB operand forwarding.
module id_ex_stage #(
    parameter int         W  = 64,
    parameter logic [4:0] ZR = 5'd31
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         id_valid,
    input  logic [4:0]   id_rn,
    input  logic [4:0]   id_rm,
    input  logic [4:0]   id_rd,
    input  logic         id_use_rm,
    input  logic [W-1:0] id_rd1,
    input  logic [W-1:0] id_rd2,
    input  logic [W-1:0] id_imm,
    input  logic [W-1:0] id_pc,
    input  logic [7:0]   id_ctrl,
    input  logic         flush,
    input  logic         mem_regwrite,
    input  logic [4:0]   mem_rd,
    input  logic [W-1:0] mem_result,
    input  logic         wb_regwrite,
    input  logic [4:0]   wb_rd,
    input  logic [W-1:0] wb_data,
    output logic         stall,
    output logic         ex_valid,
    output logic [4:0]   ex_rn,
    output logic [4:0]   ex_rm,
    output logic [4:0]   ex_rd,
    output logic [W-1:0] ex_opa,
    output logic [W-1:0] ex_opb,
    output logic [W-1:0] ex_imm,
    output logic [W-1:0] ex_pc,
    output logic [7:0]   ex_ctrl
);

    // Control word layout: {regwrite, memread, memwrite, memtoreg, alusrc, branch, aluop[1:0]}
    localparam int CTRL_MEMREAD = 6;

    logic         r_valid;
    logic [4:0]   r_rn;
    logic [4:0]   r_rm;
    logic [4:0]   r_rd;
    logic [W-1:0] r_rd1;
    logic [W-1:0] r_rd2;
    logic [W-1:0] r_imm;
    logic [W-1:0] r_pc;
    logic [7:0]   r_ctrl;

    logic         w_stall;
    logic         w_bubble;
    logic [W-1:0] w_opa;
    logic [W-1:0] w_opb;

    // Stall contract: while stall=1 the upstream PC and IF/ID hold, and this
    // stage inserts one bubble; the held instruction is captured on the next edge.
    assign w_stall = id_valid & r_valid & r_ctrl[CTRL_MEMREAD] & (r_rd != ZR) &
                     ((r_rd == id_rn) | (id_use_rm & (r_rd == id_rm)));
    assign w_bubble = flush | w_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_rn    <= '0;
            r_rm    <= '0;
            r_rd    <= '0;
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_imm   <= '0;
            r_pc    <= '0;
            r_ctrl  <= '0;
        end else if (w_bubble) begin
            // Only valid and ctrl matter in a bubble; the data fields simply hold.
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else begin
            r_valid <= id_valid;
            r_rn    <= id_rn;
            r_rm    <= id_rm;
            r_rd    <= id_rd;
            r_rd1   <= id_rd1;
            r_rd2   <= id_rd2;
            r_imm   <= id_imm;
            r_pc    <= id_pc;
            r_ctrl  <= id_valid ? id_ctrl : 8'h00;
        end
    end

    // EX/MEM is the younger producer, so it is checked before MEM/WB.
    always_comb begin
        w_opa = r_rd1;
        if (mem_regwrite && (mem_rd != ZR) && (mem_rd == r_rn)) begin
            w_opa = mem_result;
        end else if (wb_regwrite && (wb_rd != ZR) && (wb_rd == r_rn)) begin
            w_opa = wb_data;
        end
    end

    always_comb begin
        w_opb = r_rd2;
        if (mem_regwrite && (mem_rd != ZR) && (mem_rd == r_rm)) begin
            w_opb = mem_result;
        end else if (wb_regwrite && (wb_rd != ZR) && (wb_rd == r_rm)) begin
            w_opb = wb_data;
        end
    end

    assign stall    = w_stall;
    assign ex_valid = r_valid;
    assign ex_rn    = r_rn;
    assign ex_rm    = r_rm;
    assign ex_rd    = r_rd;
    assign ex_opa   = w_opa;
    assign ex_opb   = w_opb;
    assign ex_imm   = r_imm;
    assign ex_pc    = r_pc;
    assign ex_ctrl  = r_ctrl;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed cases plus a randomized run,
// with expected EX contents queued at each edge and compared after it.
module tb_id_ex_stage;

    localparam int W = 64;

    typedef struct packed {
        logic         valid;
        logic [7:0]   ctrl;
        logic [4:0]   rn;
        logic [4:0]   rm;
        logic [4:0]   rd;
        logic [W-1:0] rd1;
        logic [W-1:0] rd2;
        logic [W-1:0] imm;
        logic [W-1:0] pc;
    } ex_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         id_valid;
    logic [4:0]   id_rn, id_rm, id_rd;
    logic         id_use_rm;
    logic [W-1:0] id_rd1, id_rd2, id_imm, id_pc;
    logic [7:0]   id_ctrl;
    logic         flush;
    logic         mem_regwrite;
    logic [4:0]   mem_rd;
    logic [W-1:0] mem_result;
    logic         wb_regwrite;
    logic [4:0]   wb_rd;
    logic [W-1:0] wb_data;
    logic         stall;
    logic         ex_valid;
    logic [4:0]   ex_rn, ex_rm, ex_rd;
    logic [W-1:0] ex_opa, ex_opb, ex_imm, ex_pc;
    logic [7:0]   ex_ctrl;

    int   errors = 0;
    int   checks = 0;
    ex_t  m;
    ex_t  exp_q[$];

    id_ex_stage #(.W(W), .ZR(5'd31)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd), .id_use_rm(id_use_rm),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_pc(id_pc),
        .id_ctrl(id_ctrl), .flush(flush),
        .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall(stall), .ex_valid(ex_valid),
        .ex_rn(ex_rn), .ex_rm(ex_rm), .ex_rd(ex_rd),
        .ex_opa(ex_opa), .ex_opb(ex_opb), .ex_imm(ex_imm), .ex_pc(ex_pc),
        .ex_ctrl(ex_ctrl)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic model_stall();
        return id_valid & m.valid & m.ctrl[6] & (m.rd != 5'd31) &
               ((m.rd == id_rn) | (id_use_rm & (m.rd == id_rm)));
    endfunction

    function automatic logic [W-1:0] model_fwd(input logic [4:0] idx, input logic [W-1:0] regval);
        if (mem_regwrite && mem_rd != 5'd31 && mem_rd == idx) return mem_result;
        if (wb_regwrite && wb_rd != 5'd31 && wb_rd == idx) return wb_data;
        return regval;
    endfunction

    // One clock: check stall, push the expected EX state, advance, pop and compare.
    task automatic step();
        ex_t nxt;
        ex_t e;
        logic st;
        #1;
        st = model_stall();
        check_eq("stall", W'(stall), W'(st));
        nxt = m;
        if (reset) begin
            nxt = '0;
        end else if (flush || st) begin
            nxt.valid = 1'b0;
            nxt.ctrl  = 8'h00;
        end else begin
            nxt.valid = id_valid;
            nxt.ctrl  = id_valid ? id_ctrl : 8'h00;
            nxt.rn    = id_rn;
            nxt.rm    = id_rm;
            nxt.rd    = id_rd;
            nxt.rd1   = id_rd1;
            nxt.rd2   = id_rd2;
            nxt.imm   = id_imm;
            nxt.pc    = id_pc;
        end
        exp_q.push_back(nxt);
        m = nxt;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq("ex_valid", W'(ex_valid), W'(e.valid));
        check_eq("ex_ctrl", W'(ex_ctrl), W'(e.ctrl));
        if (e.valid) begin
            check_eq("ex_rn", W'(ex_rn), W'(e.rn));
            check_eq("ex_rm", W'(ex_rm), W'(e.rm));
            check_eq("ex_rd", W'(ex_rd), W'(e.rd));
            check_eq("ex_imm", ex_imm, e.imm);
            check_eq("ex_pc", ex_pc, e.pc);
            check_eq("ex_opa", ex_opa, model_fwd(e.rn, e.rd1));
            check_eq("ex_opb", ex_opb, model_fwd(e.rm, e.rd2));
        end
    endtask

    task automatic drive_id(input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                            input logic use_rm, input logic [7:0] ctrl);
        id_valid  = 1'b1;
        id_rn     = rn;
        id_rm     = rm;
        id_rd     = rd;
        id_use_rm = use_rm;
        id_ctrl   = ctrl;
        id_rd1    = {32'h0, $urandom()};
        id_rd2    = {32'h0, $urandom()};
        id_imm    = {$urandom(), $urandom()};
        id_pc     = {32'h0, $urandom()};
    endtask

    initial begin
        m = '0;
        reset = 1'b1; flush = 1'b0;
        mem_regwrite = 1'b0; mem_rd = 5'd0; mem_result = '0;
        wb_regwrite = 1'b0; wb_rd = 5'd0; wb_data = '0;
        drive_id(5'd7, 5'd8, 5'd9, 1'b1, 8'hFF);

        // Reset held two cycles with a live instruction in ID
        step();
        step();
        check_eq("rst_valid", W'(ex_valid), '0);
        check_eq("rst_ctrl", W'(ex_ctrl), '0);
        check_eq("rst_opa", ex_opa, '0);
        reset = 1'b0;

        // Pass-through
        drive_id(5'd1, 5'd2, 5'd4, 1'b1, 8'h82);
        id_rd1 = 64'd1; id_rd2 = 64'd2;
        step();
        check_eq("pt_opa", ex_opa, 64'd1);
        check_eq("pt_opb", ex_opb, 64'd2);
        check_eq("pt_ctrl", W'(ex_ctrl), W'(8'h82));
        check_eq("pt_valid", W'(ex_valid), W'(1'b1));

        // Forward priority on operand A
        drive_id(5'd5, 5'd6, 5'd4, 1'b1, 8'h80);
        id_rd1 = 64'h11;
        step();
        mem_regwrite = 1'b1; mem_rd = 5'd5; mem_result = 64'hAA;
        wb_regwrite = 1'b1; wb_rd = 5'd5; wb_data = 64'hBB;
        #1 check_eq("fwd_mem_wins", ex_opa, 64'hAA);
        mem_regwrite = 1'b0;
        #1 check_eq("fwd_wb", ex_opa, 64'hBB);
        mem_regwrite = 1'b1; mem_rd = 5'd31; wb_rd = 5'd31;
        #1 check_eq("fwd_zr", ex_opa, 64'h11);
        mem_regwrite = 1'b0; wb_regwrite = 1'b0;

        // Load-use: LDUR X3 then ADD reading X3 as rm
        drive_id(5'd1, 5'd0, 5'd3, 1'b0, 8'hD8);
        step();
        drive_id(5'd2, 5'd3, 5'd4, 1'b1, 8'h82);
        #1 check_eq("lu_stall", W'(stall), W'(1'b1));
        step();
        check_eq("lu_bubble", W'(ex_valid), '0);
        check_eq("lu_unstall", W'(stall), '0);
        step();
        wb_regwrite = 1'b1; wb_rd = 5'd3; wb_data = 64'hDEAD_BEEF_0000_0003;
        #1 check_eq("lu_fwd_opb", ex_opb, 64'hDEAD_BEEF_0000_0003);
        check_eq("lu_valid", W'(ex_valid), W'(1'b1));
        wb_regwrite = 1'b0;

        // Load to XZR never stalls
        drive_id(5'd1, 5'd0, 5'd31, 1'b0, 8'hD8);
        step();
        drive_id(5'd2, 5'd31, 5'd4, 1'b1, 8'h82);
        #1 check_eq("zr_nostall", W'(stall), '0);
        step();

        // Flush coinciding with a stall
        drive_id(5'd1, 5'd0, 5'd3, 1'b0, 8'hD8);
        step();
        drive_id(5'd3, 5'd2, 5'd4, 1'b1, 8'h82);
        flush = 1'b1;
        #1 check_eq("fl_stall", W'(stall), W'(1'b1));
        step();
        check_eq("fl_valid", W'(ex_valid), '0);
        check_eq("fl_ctrl", W'(ex_ctrl), '0);
        flush = 1'b0;
        step();
        check_eq("fl_resume", W'(ex_ctrl), W'(8'h82));

        // Reset during a stall
        drive_id(5'd1, 5'd0, 5'd3, 1'b0, 8'hD8);
        step();
        drive_id(5'd3, 5'd2, 5'd4, 1'b1, 8'h82);
        #1 check_eq("rs_stall", W'(stall), W'(1'b1));
        reset = 1'b1;
        step();
        check_eq("rs_valid", W'(ex_valid), '0);
        reset = 1'b0;
        step();

        // Randomized traffic over a small register set to provoke hazards
        for (int i = 0; i < 60; i++) begin
            logic [4:0] regs [5];
            regs[0] = 5'd1; regs[1] = 5'd2; regs[2] = 5'd3; regs[3] = 5'd4; regs[4] = 5'd31;
            drive_id(regs[$urandom_range(0, 4)], regs[$urandom_range(0, 4)],
                     regs[$urandom_range(0, 4)], 1'($urandom_range(0, 1)),
                     8'($urandom_range(0, 255)));
            id_valid     = ($urandom_range(0, 7) != 0);
            flush        = ($urandom_range(0, 7) == 0);
            mem_regwrite = 1'($urandom_range(0, 1));
            mem_rd       = regs[$urandom_range(0, 4)];
            mem_result   = {$urandom(), $urandom()};
            wb_regwrite  = 1'($urandom_range(0, 1));
            wb_rd        = regs[$urandom_range(0, 4)];
            wb_data      = {$urandom(), $urandom()};
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
